pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning payload width in bits (legal 1..1024).
REQ-002 SHALL have parameter SKID, default 1, meaning 1 selects the two-entry skid stage and 0 selects the single-entry pass-through stage.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port flush  input  1  kills every held entry (pipeline bubble/flush).
REQ-006 SHALL have port in_valid  input  1  upstream has a payload.
REQ-007 SHALL have port in_ready  output  1  stage can take a payload this cycle.
REQ-008 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL have port out_valid  output  1  stage presents a payload.
REQ-010 SHALL have port out_ready  input  1  downstream takes the payload this cycle.
REQ-011 SHALL have port out_data  output  DATA_W  presented payload.
REQ-012 SHALL have port occupancy  output  2  number of held entries (0..2).

Function
REQ-013 SHALL accept a payload when in_valid and in_ready are both 1 at a rising edge; SHALL emit one when out_valid and out_ready are both 1.
REQ-014 SHALL deliver payloads in acceptance order, without loss or duplication, absent flush.
REQ-015 (SKID=1) SHALL implement states EMPTY (occupancy 0), ONE (main slot valid, occupancy 1) and FULL (main and skid slots valid, occupancy 2).
REQ-016 (SKID=1) SHALL drive in_ready as the registered condition "state != FULL", with no combinational path from out_ready.
REQ-017 (SKID=1) SHALL make the transitions: EMPTY+accept -> ONE; ONE+accept+no emit -> FULL (payload into skid slot); ONE+emit+no accept -> EMPTY; ONE+accept+emit -> ONE (new payload into main slot); FULL+emit -> ONE (skid moves to main); all others hold.
REQ-018 SHALL drive out_valid and out_data from the main slot only; latency from accept to out_valid is 1 cycle when the stage is EMPTY.
REQ-019 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 (SKID=0) SHALL use one slot with in_ready = !out_valid || out_ready (combinational), so accept and emit in the same cycle sustain one payload per cycle; occupancy is 0 or 1.
REQ-021 SHALL, on flush=1, make occupancy 0, out_valid 0 and all payload slots 0 at the next edge, regardless of in_valid or out_ready.
REQ-022 SHALL give flush priority over a simultaneous accept: the payload offered in the flush cycle is dropped, although in_ready may read 1.
REQ-023 SHALL drive out_data to 0 whenever out_valid=0.

Reset
REQ-024 SHALL, when rst=1 at an edge, set state EMPTY, occupancy 0, out_valid 0, out_data 0 and skid slot 0; in_ready is 1 in the following cycle.
REQ-025 SHALL give rst priority over flush and handshakes; rst asserted mid-transfer discards all held payloads.

Structure
REQ-026 SHALL place the state encoding (EMPTY=2'b00, ONE=2'b01, FULL=2'b10) and the default DATA_W constant in shared package pipe_pkg.
REQ-027 SHALL build each slot from one sub-module, pipe_slot (valid bit plus DATA_W payload, with load and clear inputs); SKID=1 instantiates two and SKID=0 instantiates one.

Verification
REQ-028 SHALL cover streaming: SKID=1, in_valid=1 with data 1,2,3,4 on consecutive cycles and out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, starting one cycle after the first accept, with occupancy 1 throughout.
REQ-029 SHALL cover backpressure: accept 0xA then 0xB while out_ready=0 -> occupancy 2, in_ready 0, out_data 0xA held; then out_ready=1 for 2 cycles -> 0xA, 0xB, then occupancy 0.
REQ-030 SHALL cover flush in FULL: flush=1 with in_valid=1 and data 0xC -> next cycle occupancy 0, out_valid 0, out_data 0, and 0xC is never emitted.
REQ-031 SHALL cover reset mid-stream: rst=1 while FULL -> next cycle out_valid 0, in_ready 1, occupancy 0.
REQ-032 SHALL cover SKID=0 mode: out_ready=1 and a continuous input of 5,6,7 -> one output per cycle; out_ready=0 while holding 5 -> in_ready 0 in the same cycle.
REQ-033 SHALL check random valid/ready against a reference FIFO model: order preserved, no payload lost except by flush, no payload duplicated.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid register: state encoding,
// default payload width and a state-to-occupancy helper.
package pipe_pkg;

    // Default payload width in bits.
    localparam int unsigned DefaultDataW = 64;

    // Occupancy states of the two-entry skid stage.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StFull  = 2'b10
    } pipe_state_e;

    // Number of held entries implied by a skid-stage state.
    function automatic logic [1:0] state_occupancy(pipe_state_e st);
        logic [1:0] occ;
        unique case (st)
            StEmpty: occ = 2'd0;
            StOne:   occ = 2'd1;
            StFull:  occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: a valid bit plus payload. Clear wins over load so a
// flush always leaves the slot empty and zeroed.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_d, valid_q;
    logic [DATA_W-1:0] data_d, data_q;

    // Next-state: clear empties and zeroes the slot, load captures new payload.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    // Slot register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register. SKID=1 builds a two-entry skid buffer whose
// in_ready is purely registered; SKID=0 builds a single-entry stage whose
// in_ready looks through to out_ready for full throughput.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic accept;
    logic emit;

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    if (SKID != 0) begin : g_skid

        pipe_state_e       state_q, state_d;
        logic              main_load, main_clear, skid_load, skid_clear;
        logic [DATA_W-1:0] main_din;
        logic              main_valid, skid_valid;
        logic [DATA_W-1:0] main_data, skid_data;

        // Next-state and slot control; flush overrides every handshake.
        always_comb begin
            state_d    = state_q;
            main_load  = 1'b0;
            main_clear = 1'b0;
            skid_load  = 1'b0;
            skid_clear = 1'b0;
            main_din   = in_data;
            if (flush) begin
                main_clear = 1'b1;
                skid_clear = 1'b1;
                state_d    = StEmpty;
            end else begin
                unique case (state_q)
                    StEmpty: begin
                        if (accept) begin
                            main_load = 1'b1;
                            state_d   = StOne;
                        end
                    end
                    StOne: begin
                        if (accept && !emit) begin
                            // Main slot is stalled: park the new payload aside.
                            skid_load = 1'b1;
                            state_d   = StFull;
                        end else if (!accept && emit) begin
                            main_clear = 1'b1;
                            state_d    = StEmpty;
                        end else if (accept && emit) begin
                            main_load = 1'b1;
                        end
                    end
                    StFull: begin
                        // in_ready is low here, so only the drain can happen.
                        if (emit && skid_valid) begin
                            main_load  = 1'b1;
                            main_din   = skid_data;
                            skid_clear = 1'b1;
                            state_d    = StOne;
                        end
                    end
                    default: begin
                        main_clear = 1'b1;
                        skid_clear = 1'b1;
                        state_d    = StEmpty;
                    end
                endcase
            end
        end

        // State register with synchronous reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= StEmpty;
            end else begin
                state_q <= state_d;
            end
        end

        pipe_slot #(
            .DATA_W (DATA_W)
        ) u_main (
            .clk     (clk),
            .rst     (rst),
            .load_i  (main_load),
            .clear_i (main_clear),
            .data_i  (main_din),
            .valid_o (main_valid),
            .data_o  (main_data)
        );

        pipe_slot #(
            .DATA_W (DATA_W)
        ) u_skid (
            .clk     (clk),
            .rst     (rst),
            .load_i  (skid_load),
            .clear_i (skid_clear),
            .data_i  (in_data),
            .valid_o (skid_valid),
            .data_o  (skid_data)
        );

        // Registered ready: no combinational path from out_ready.
        assign in_ready  = (state_q != StFull);
        assign out_valid = main_valid;
        assign out_data  = main_valid ? main_data : '0;
        assign occupancy = state_occupancy(state_q);

    end else begin : g_pass

        logic              slot_load, slot_clear;
        logic              main_valid;
        logic [DATA_W-1:0] main_data;

        // Load on accept (replacing any payload leaving this cycle), clear on
        // a pure drain or a flush.
        always_comb begin
            slot_load  = 1'b0;
            slot_clear = 1'b0;
            if (flush) begin
                slot_clear = 1'b1;
            end else if (accept) begin
                slot_load = 1'b1;
            end else if (emit) begin
                slot_clear = 1'b1;
            end
        end

        pipe_slot #(
            .DATA_W (DATA_W)
        ) u_main (
            .clk     (clk),
            .rst     (rst),
            .load_i  (slot_load),
            .clear_i (slot_clear),
            .data_i  (in_data),
            .valid_o (main_valid),
            .data_o  (main_data)
        );

        assign in_ready  = !main_valid || out_ready;
        assign out_valid = main_valid;
        assign out_data  = main_valid ? main_data : '0;
        assign occupancy = {1'b0, main_valid};

    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and random checks for pipe_skid_reg in both SKID modes.
module tb_pipe_skid_reg;

    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    // SKID=1 instance signals
    logic          flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    // SKID=0 instance signals
    logic          s0_flush = 1'b0, s0_in_valid = 1'b0, s0_out_ready = 1'b0;
    logic [DW-1:0] s0_in_data = '0;
    logic          s0_in_ready, s0_out_valid;
    logic [DW-1:0] s0_out_data;
    logic [1:0]    s0_occupancy;

    int n_cmp  = 0;
    int n_fail = 0;

    pipe_skid_reg #(.DATA_W(DW), .SKID(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    pipe_skid_reg #(.DATA_W(DW), .SKID(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .flush     (s0_flush),
        .in_valid  (s0_in_valid),
        .in_ready  (s0_in_ready),
        .in_data   (s0_in_data),
        .out_valid (s0_out_valid),
        .out_ready (s0_out_ready),
        .out_data  (s0_out_data),
        .occupancy (s0_occupancy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
        n_cmp++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (s0_occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_s0_occ got %0d want 0", s0_occupancy); end
        n_cmp++; if (s0_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s0_in_ready got %b want 1", s0_in_ready); end
    endtask

    task automatic test_stream;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = DW'(i);
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_data !== DW'(i)) begin n_fail++; $display("FAIL stream_data[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, DW'(i)); end
            n_cmp++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d] got %0d want 1", i, occupancy); end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got occ=%0d v=%b want occ=0 v=0", occupancy, out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h000A;
        tick();
        n_cmp++; if (occupancy !== 2'd1 || out_data !== 16'h000A || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_one got occ=%0d d=%h rdy=%b want occ=1 d=000a rdy=1", occupancy, out_data, in_ready); end
        in_data = 16'h000B;
        tick();
        in_valid = 1'b0;
        settle();
        n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_full_occ got %0d want 2", occupancy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'h000A) begin n_fail++; $display("FAIL bp_hold got v=%b d=%h want v=1 d=000a", out_valid, out_data); end
        tick();
        n_cmp++; if (out_data !== 16'h000A || occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_stable got d=%h occ=%0d want d=000a occ=2", out_data, occupancy); end
        out_ready = 1'b1;
        settle();
        // in_ready must not follow out_ready within the cycle
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_reg_ready got %b want 0", in_ready); end
        tick();
        n_cmp++; if (out_data !== 16'h000B || occupancy !== 2'd1) begin n_fail++; $display("FAIL bp_drain1 got d=%h occ=%0d want d=000b occ=1", out_data, occupancy); end
        tick();
        n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL bp_drain2 got occ=%0d v=%b d=%h want 0 0 0", occupancy, out_valid, out_data); end
        out_ready = 1'b0;
    endtask

    task automatic fill_full(input logic [DW-1:0] a, input logic [DW-1:0] b);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = a;
        tick();
        in_data = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_flush_full;
        logic seen;
        fill_full(16'h0001, 16'h0002);
        n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ got %0d want 2", occupancy); end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h000C;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        settle();
        n_cmp++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occ got %0d want 0", occupancy); end
        n_cmp++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL flush_out got v=%b d=%h want v=0 d=0", out_valid, out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_dropped got emitted=%b want 0", seen); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        fill_full(16'h0003, 16'h0004);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0009;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        settle();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        n_cmp++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL rstmid_occ got %0d want 0", occupancy); end
    endtask

    task automatic test_skid0;
        s0_out_ready = 1'b1;
        s0_in_valid  = 1'b1;
        for (int v = 5; v <= 7; v++) begin
            s0_in_data = DW'(v);
            settle();
            n_cmp++; if (s0_in_ready !== 1'b1) begin n_fail++; $display("FAIL s0_stream_rdy[%0d] got %b want 1", v, s0_in_ready); end
            tick();
            n_cmp++; if (s0_out_valid !== 1'b1 || s0_out_data !== DW'(v) || s0_occupancy !== 2'd1) begin n_fail++; $display("FAIL s0_stream[%0d] got v=%b d=%h occ=%0d want v=1 d=%h occ=1", v, s0_out_valid, s0_out_data, s0_occupancy, DW'(v)); end
        end
        s0_in_valid = 1'b0;
        tick();
        n_cmp++; if (s0_occupancy !== 2'd0 || s0_out_data !== '0) begin n_fail++; $display("FAIL s0_drain got occ=%0d d=%h want 0 0", s0_occupancy, s0_out_data); end
        s0_in_valid = 1'b1;
        s0_in_data  = 16'h0005;
        tick();
        s0_in_valid  = 1'b0;
        s0_out_ready = 1'b0;
        settle();
        n_cmp++; if (s0_in_ready !== 1'b0) begin n_fail++; $display("FAIL s0_stall_rdy got %b want 0", s0_in_ready); end
        n_cmp++; if (s0_out_data !== 16'h0005) begin n_fail++; $display("FAIL s0_hold got %h want 0005", s0_out_data); end
        s0_out_ready = 1'b1;
        settle();
        n_cmp++; if (s0_in_ready !== 1'b1) begin n_fail++; $display("FAIL s0_lookthrough_rdy got %b want 1", s0_in_ready); end
        tick();
        n_cmp++; if (s0_occupancy !== 2'd0) begin n_fail++; $display("FAIL s0_final_occ got %0d want 0", s0_occupancy); end
        s0_out_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [DW-1:0] q1[$];
        logic [DW-1:0] q0[$];
        logic          acc1, emt1, acc0, emt0, exp_rdy0;
        logic [DW-1:0] exp1, exp0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            in_valid     = ($urandom_range(0, 9) < 7);
            out_ready    = ($urandom_range(0, 9) < 6);
            flush        = ($urandom_range(0, 19) == 0);
            in_data      = DW'($urandom);
            s0_in_valid  = ($urandom_range(0, 9) < 7);
            s0_out_ready = ($urandom_range(0, 9) < 6);
            s0_flush     = ($urandom_range(0, 19) == 0);
            s0_in_data   = DW'($urandom);
            settle();
            exp_rdy0 = (q0.size() == 0) || s0_out_ready;
            n_cmp++; if (in_ready !== (q1.size() < 2)) begin n_fail++; $display("FAIL rnd_rdy1[%0d] got %b want %b", c, in_ready, q1.size() < 2); end
            n_cmp++; if (s0_in_ready !== exp_rdy0) begin n_fail++; $display("FAIL rnd_rdy0[%0d] got %b want %b", c, s0_in_ready, exp_rdy0); end
            acc1 = in_valid && (q1.size() < 2);
            emt1 = out_ready && (q1.size() > 0);
            acc0 = s0_in_valid && exp_rdy0;
            emt0 = s0_out_ready && (q0.size() > 0);
            tick();
            if (emt1) void'(q1.pop_front());
            if (flush) q1.delete();
            else if (acc1) q1.push_back(in_data);
            if (emt0) void'(q0.pop_front());
            if (s0_flush) q0.delete();
            else if (acc0) q0.push_back(s0_in_data);
            exp1 = (q1.size() > 0) ? q1[0] : '0;
            exp0 = (q0.size() > 0) ? q0[0] : '0;
            n_cmp++; if (occupancy !== 2'(q1.size()) || out_valid !== (q1.size() > 0) || out_data !== exp1) begin n_fail++; $display("FAIL rnd_out1[%0d] got occ=%0d v=%b d=%h want occ=%0d d=%h", c, occupancy, out_valid, out_data, q1.size(), exp1); end
            n_cmp++; if (s0_occupancy !== 2'(q0.size()) || s0_out_valid !== (q0.size() > 0) || s0_out_data !== exp0) begin n_fail++; $display("FAIL rnd_out0[%0d] got occ=%0d v=%b d=%h want occ=%0d d=%h", c, s0_occupancy, s0_out_valid, s0_out_data, q0.size(), exp0); end
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        s0_in_valid = 1'b0; s0_out_ready = 1'b0; s0_flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_reset_mid();
        test_skid0();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
